// File: rtl/memory_bank_sequencer_pkg.sv
// Shared types and default sizing for the memory bank sequencer and its read-path peers.
package mem_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int DEFAULT_ADDR_W    = 11;
  localparam int DEFAULT_NUM_BANKS = 4;

endpackage

// File: rtl/memory_bank_sequencer_if.sv
// Control/status bundle between the control FSM (master) and the bank sequencer (slave).
interface memory_bank_sequencer_if
  import mem_seq_pkg::*;
#(
  parameter int ADDR_W    = DEFAULT_ADDR_W,
  parameter int NUM_BANKS = DEFAULT_NUM_BANKS
) ();

  localparam int BANK_W = $clog2(NUM_BANKS);

  logic                 CE;
  logic                 start;
  logic                 stop;
  logic                 continuous;
  logic [ADDR_W-1:0]    last_addr;
  logic [ADDR_W-1:0]    addr;
  logic [BANK_W-1:0]    bank_idx;
  logic [NUM_BANKS-1:0] bank_sel;
  logic                 mem_we;
  logic                 busy;
  logic                 done;
  logic                 wrap;

  modport master (
    output CE, start, stop, continuous, last_addr,
    input  addr, bank_idx, bank_sel, mem_we, busy, done, wrap
  );

  modport slave (
    input  CE, start, stop, continuous, last_addr,
    output addr, bank_idx, bank_sel, mem_we, busy, done, wrap
  );

endinterface

// File: rtl/memory_bank_sequencer_bank_decoder.sv
// Bank index to one-hot select decoder, gated by an enable; shared by write and read paths.
module bank_decoder #(
  parameter int NUM_BANKS = 4
) (
  input  logic [$clog2(NUM_BANKS)-1:0] idx,
  input  logic                         en,
  output logic [NUM_BANKS-1:0]         onehot
);

  localparam int BANK_W = $clog2(NUM_BANKS);

  always_comb begin
    onehot = '0;
    for (int i = 0; i < NUM_BANKS; i++) begin
      onehot[i] = en && (idx == BANK_W'(i));
    end
  end

endmodule

// File: rtl/memory_bank_sequencer.sv
// Address/bank sequencer: walks 0..last_addr in each of NUM_BANKS banks, single-pass or wrapping.
module memory_bank_sequencer
  import mem_seq_pkg::*;
#(
  parameter int ADDR_W    = DEFAULT_ADDR_W,
  parameter int NUM_BANKS = DEFAULT_NUM_BANKS
) (
  input logic                    CLK,
  input logic                    RESET,
  memory_bank_sequencer_if.slave bus
);

  localparam int                BANK_W    = $clog2(NUM_BANKS);
  localparam logic [BANK_W-1:0] LAST_BANK = BANK_W'(NUM_BANKS - 1);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q,  addr_d;
  logic [BANK_W-1:0]   bank_q,  bank_d;
  logic [ADDR_W-1:0]   last_q,  last_d;
  logic                cont_q,  cont_d;
  logic                wrap_q,  wrap_d;
  logic                run;

  // NOTE: every _d gets its hold value first, so no path through the case can infer a latch.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    bank_d  = bank_q;
    last_d  = last_q;
    cont_d  = cont_q;
    wrap_d  = wrap_q;

    if (bus.CE) begin
      wrap_d = 1'b0;
      unique case (state_q)
        IDLE: begin
          if (bus.start && !bus.stop) begin
            state_d = RUN;
            last_d  = bus.last_addr;
            cont_d  = bus.continuous;
            addr_d  = '0;
            bank_d  = '0;
          end
        end
        RUN: begin
          if (bus.stop) begin
            state_d = IDLE;
            addr_d  = '0;
            bank_d  = '0;
          end else if (addr_q < last_q) begin
            addr_d = addr_q + ADDR_W'(1);
          end else if (bank_q != LAST_BANK) begin
            addr_d = '0;
            bank_d = bank_q + BANK_W'(1);
          end else if (cont_q) begin
            // Last address of last bank in continuous mode: restart and flag the wrap.
            addr_d = '0;
            bank_d = '0;
            wrap_d = 1'b1;
          end else begin
            state_d = DONE;
          end
        end
        DONE: begin
          state_d = IDLE;
          addr_d  = '0;
          bank_d  = '0;
        end
        default: begin
          state_d = IDLE;
          addr_d  = '0;
          bank_d  = '0;
        end
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q <= IDLE;
      addr_q  <= '0;
      bank_q  <= '0;
      last_q  <= '0;
      cont_q  <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      bank_q  <= bank_d;
      last_q  <= last_d;
      cont_q  <= cont_d;
      wrap_q  <= wrap_d;
    end
  end

  assign run          = (state_q == RUN);
  assign bus.addr     = addr_q;
  assign bus.bank_idx = bank_q;
  assign bus.wrap     = wrap_q;
  assign bus.busy     = run;
  assign bus.done     = (state_q == DONE);
  assign bus.mem_we   = run && bus.CE;

  bank_decoder #(
    .NUM_BANKS (NUM_BANKS)
  ) u_bank_decoder (
    .idx    (bank_q),
    .en     (run),
    .onehot (bus.bank_sel)
  );

endmodule

// File: tb/tb_memory_bank_sequencer.sv
// Self-checking bench: per-cycle vector table plus scoreboarded multi-cycle sequences.
module tb_memory_bank_sequencer;

  localparam int AW = 11;
  localparam int NB = 4;
  localparam int BW = 2;

  logic CLK   = 1'b0;
  logic RESET = 1'b0;
  always #5 CLK = ~CLK;

  memory_bank_sequencer_if #(.ADDR_W(AW), .NUM_BANKS(NB)) bus ();

  memory_bank_sequencer #(.ADDR_W(AW), .NUM_BANKS(NB)) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus)
  );

  typedef struct {
    logic          ce, start, stop, cont;
    logic [AW-1:0] last;
    logic [AW-1:0] e_addr;
    logic [BW-1:0] e_bank;
    logic [NB-1:0] e_sel;
    logic          e_we, e_busy, e_done, e_wrap;
  } vec_t;

  int n_tests = 0;
  int n_fail  = 0;

  logic [BW+AW-1:0] exp_q[$];
  bit mon_en = 1'b0;
  int wr_cnt, busy_cnt, done_cnt, wrap_cnt;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic vec_t mk(input logic ce, st, sp, ct, input int last,
                              input int ea, input int eb, input logic [NB-1:0] es,
                              input logic ew, eu, ed, ep);
    vec_t v;
    v.ce = ce; v.start = st; v.stop = sp; v.cont = ct; v.last = AW'(last);
    v.e_addr = AW'(ea); v.e_bank = BW'(eb); v.e_sel = es;
    v.e_we = ew; v.e_busy = eu; v.e_done = ed; v.e_wrap = ep;
    return v;
  endfunction

  function automatic logic [63:0] outs();
    return 64'({bus.addr, bus.bank_idx, bus.bank_sel, bus.mem_we, bus.busy, bus.done, bus.wrap});
  endfunction

  // Scoreboard monitor: one expected {bank, addr} entry consumed per write strobe.
  always @(negedge CLK) begin
    if (mon_en) begin
      if (bus.mem_we) begin
        wr_cnt++;
        if (exp_q.size() == 0) begin
          check("sb_underflow", 64'(wr_cnt), 64'(0));
        end else begin
          logic [BW+AW-1:0] e;
          logic [NB-1:0]    sel;
          e   = exp_q.pop_front();
          sel = NB'(1) << e[AW +: BW];
          check("sb_write", 64'({bus.bank_idx, bus.addr, bus.bank_sel}), 64'({e, sel}));
        end
      end
      if (bus.busy) busy_cnt++;
      if (bus.done) done_cnt++;
      if (bus.wrap) wrap_cnt++;
    end
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_inputs();
    bus.CE = 1'b1; bus.start = 1'b0; bus.stop = 1'b0;
    bus.continuous = 1'b0; bus.last_addr = '0;
  endtask

  task automatic mon_clear();
    exp_q.delete();
    wr_cnt = 0; busy_cnt = 0; done_cnt = 0; wrap_cnt = 0;
  endtask

  // Expected write order: addresses fastest, then banks, wrapping to bank 0.
  task automatic push_pass(input int last, input int n);
    for (int i = 0; i < n; i++) begin
      exp_q.push_back({BW'((i / (last + 1)) % NB), AW'(i % (last + 1))});
    end
  endtask

  vec_t vecs[22];

  initial begin
    //              ce st sp ct last  addr bank sel     we bsy dn wr
    vecs[0]  = mk(1, 1, 1, 0, 5,    0, 0, 4'b0000, 0, 0, 0, 0);
    vecs[1]  = mk(1, 1, 0, 0, 0,    0, 0, 4'b0001, 1, 1, 0, 0);
    vecs[2]  = mk(1, 0, 0, 0, 0,    0, 1, 4'b0010, 1, 1, 0, 0);
    vecs[3]  = mk(1, 0, 0, 0, 0,    0, 2, 4'b0100, 1, 1, 0, 0);
    vecs[4]  = mk(1, 0, 0, 0, 0,    0, 3, 4'b1000, 1, 1, 0, 0);
    vecs[5]  = mk(1, 0, 0, 0, 0,    0, 3, 4'b0000, 0, 0, 1, 0);
    vecs[6]  = mk(1, 0, 0, 0, 0,    0, 0, 4'b0000, 0, 0, 0, 0);
    vecs[7]  = mk(0, 1, 0, 0, 3,    0, 0, 4'b0000, 0, 0, 0, 0);
    vecs[8]  = mk(1, 1, 0, 1, 1,    0, 0, 4'b0001, 1, 1, 0, 0);
    vecs[9]  = mk(1, 0, 0, 0, 3,    1, 0, 4'b0001, 1, 1, 0, 0);
    vecs[10] = mk(0, 0, 0, 0, 3,    1, 0, 4'b0001, 0, 1, 0, 0);
    vecs[11] = mk(1, 0, 0, 0, 3,    0, 1, 4'b0010, 1, 1, 0, 0);
    vecs[12] = mk(1, 1, 0, 0, 3,    1, 1, 4'b0010, 1, 1, 0, 0);
    vecs[13] = mk(1, 0, 0, 0, 3,    0, 2, 4'b0100, 1, 1, 0, 0);
    vecs[14] = mk(1, 0, 0, 0, 3,    1, 2, 4'b0100, 1, 1, 0, 0);
    vecs[15] = mk(1, 0, 0, 0, 3,    0, 3, 4'b1000, 1, 1, 0, 0);
    vecs[16] = mk(1, 0, 0, 0, 3,    1, 3, 4'b1000, 1, 1, 0, 0);
    vecs[17] = mk(1, 0, 0, 0, 3,    0, 0, 4'b0001, 1, 1, 0, 1);
    vecs[18] = mk(0, 0, 0, 0, 3,    0, 0, 4'b0001, 0, 1, 0, 1);
    vecs[19] = mk(1, 0, 0, 0, 3,    1, 0, 4'b0001, 1, 1, 0, 0);
    vecs[20] = mk(1, 0, 1, 0, 3,    0, 0, 4'b0000, 0, 0, 0, 0);
    vecs[21] = mk(1, 0, 0, 0, 0,    0, 0, 4'b0000, 0, 0, 0, 0);

    idle_inputs();
    mon_clear();
    RESET = 1'b0;
    #12;
    check("reset_state", outs(), 64'(0));
    @(posedge CLK);
    #1;
    RESET = 1'b1;

    // Cycle-by-cycle vectors: outputs sampled just after the edge that consumed the inputs.
    for (int i = 0; i < 22; i++) begin
      bus.CE = vecs[i].ce; bus.start = vecs[i].start; bus.stop = vecs[i].stop;
      bus.continuous = vecs[i].cont; bus.last_addr = vecs[i].last;
      step();
      check($sformatf("vec%0d", i), outs(),
            64'({vecs[i].e_addr, vecs[i].e_bank, vecs[i].e_sel,
                 vecs[i].e_we, vecs[i].e_busy, vecs[i].e_done, vecs[i].e_wrap}));
    end
    idle_inputs();

    // Single pass, last_addr=2: 12 writes, 12 busy cycles, one done cycle.
    mon_clear(); mon_en = 1'b1;
    bus.start = 1'b1; bus.last_addr = AW'(2);
    push_pass(2, 12);
    step();
    bus.start = 1'b0;
    repeat (20) step();
    mon_en = 1'b0;
    check("single_writes", 64'(wr_cnt), 64'(12));
    check("single_busy",   64'(busy_cnt), 64'(12));
    check("single_done",   64'(done_cnt), 64'(1));
    check("single_sb_left", 64'(exp_q.size()), 64'(0));
    check("single_idle",   outs(), 64'(0));

    // last_addr and continuous changed mid-run must not alter the latched sequence.
    mon_clear(); mon_en = 1'b1;
    bus.start = 1'b1; bus.last_addr = AW'(2);
    push_pass(2, 12);
    step();
    bus.start = 1'b0;
    repeat (4) step();
    bus.last_addr = AW'(7); bus.continuous = 1'b1;
    repeat (16) step();
    mon_en = 1'b0;
    check("latch_writes", 64'(wr_cnt), 64'(12));
    check("latch_done",   64'(done_cnt), 64'(1));
    check("latch_wrap",   64'(wrap_cnt), 64'(0));
    check("latch_sb_left", 64'(exp_q.size()), 64'(0));
    idle_inputs();

    // CE toggling every cycle: progress only on enabled edges.
    mon_clear(); mon_en = 1'b1;
    bus.start = 1'b1; bus.last_addr = AW'(2);
    push_pass(2, 12);
    step();
    bus.start = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      bus.CE = (k % 2 == 0);
      step();
    end
    mon_en = 1'b0;
    check("ce_writes", 64'(wr_cnt), 64'(12));
    check("ce_busy",   64'(busy_cnt), 64'(24));
    check("ce_done",   64'(done_cnt), 64'(2));
    check("ce_sb_left", 64'(exp_q.size()), 64'(0));
    idle_inputs();

    // Continuous mode, last_addr=1: wraps every 8 cycles, stopped after 20 writes.
    mon_clear(); mon_en = 1'b1;
    bus.start = 1'b1; bus.continuous = 1'b1; bus.last_addr = AW'(1);
    push_pass(1, 20);
    step();
    bus.start = 1'b0;
    repeat (19) step();
    bus.stop = 1'b1;
    step();
    mon_en = 1'b0;
    bus.stop = 1'b0;
    check("cont_writes", 64'(wr_cnt), 64'(20));
    check("cont_busy",   64'(busy_cnt), 64'(20));
    check("cont_wraps",  64'(wrap_cnt), 64'(2));
    check("cont_done",   64'(done_cnt), 64'(0));
    check("cont_stopped", outs(), 64'(0));
    idle_inputs();

    // Asynchronous reset with the sequence at bank 1, address 3.
    bus.start = 1'b1; bus.last_addr = AW'(5);
    step();
    bus.start = 1'b0;
    repeat (9) step();
    check("pre_reset_pos", 64'({bus.bank_idx, bus.addr, bus.busy}), 64'({BW'(1), AW'(3), 1'b1}));
    #2;
    RESET = 1'b0;
    #1;
    check("async_reset", outs(), 64'(0));
    @(posedge CLK);
    #1;
    RESET = 1'b1;
    step();
    check("post_reset_idle", outs(), 64'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
